// File: rtl/buf_share_pkg.sv
// buf_share_pkg: shared constants and requester index type for the shared buffer controller
package buf_share_pkg;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);
    localparam int NREQ  = 2;
    typedef enum logic {REQ0 = 1'b0, REQ1 = 1'b1} req_idx_t;
endpackage

// File: rtl/buf_share_ctrl_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter with one-hot grant
module rr_arb2
    import buf_share_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [NREQ-1:0] req,
    input  logic            enable,
    input  logic            advance,
    output logic [NREQ-1:0] gnt
);
    req_idx_t pri_q, pri_d;
    always_comb begin
        gnt   = !enable ? 2'b00 : (&req) ? (pri_q == REQ1 ? 2'b10 : 2'b01) : req;
        pri_d = advance ? (gnt[0] ? REQ1 : REQ0) : pri_q;
    end
    always_ff @(posedge clk) begin
        if (rst || flush) pri_q <= REQ0;
        else pri_q <= pri_d;
    end
endmodule

// File: rtl/buf_share_ctrl.sv
// buf_share_ctrl: 16x32 circular buffer shared by two producers and two consumers
module buf_share_ctrl
    import buf_share_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [NREQ-1:0]  wr_req,
    input  logic [WIDTH-1:0] wr_data0,
    input  logic [WIDTH-1:0] wr_data1,
    output logic [NREQ-1:0]  wr_gnt,
    input  logic [NREQ-1:0]  rd_req,
    output logic [NREQ-1:0]  rd_gnt,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] ram [DEPTH];
    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]      count_q, count_d;
    logic             clr, do_wr, do_rd;
    assign clr   = rst | flush;
    assign full  = count_q == (AW+1)'(DEPTH);
    assign empty = count_q == '0;
    assign count = count_q;
    rr_arb2 u_wr_arb (
        .clk(clk), .rst(rst), .flush(flush), .req(wr_req),
        .enable(!full && !clr), .advance(do_wr), .gnt(wr_gnt)
    );
    rr_arb2 u_rd_arb (
        .clk(clk), .rst(rst), .flush(flush), .req(rd_req),
        .enable(!empty && !clr), .advance(do_rd), .gnt(rd_gnt)
    );
    // pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        do_wr   = |(wr_req & wr_gnt);
        do_rd   = |(rd_req & rd_gnt);
        wp_d    = clr ? '0 : wp_q + AW'(do_wr);
        rp_d    = clr ? '0 : rp_q + AW'(do_rd);
        count_d = clr ? '0 : count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        rd_data = |rd_gnt ? ram[rp_q] : '0;
    end
    always_ff @(posedge clk) begin
        wp_q    <= wp_d;
        rp_q    <= rp_d;
        count_q <= count_d;
    end
    always_ff @(posedge clk) begin
        if (do_wr) ram[wp_q] <= wr_gnt[1] ? wr_data1 : wr_data0;
    end
endmodule

// File: tb/tb_buf_share_ctrl.sv
// tb_buf_share_ctrl: directed stimulus with a read-data scoreboard for buf_share_ctrl
module tb_buf_share_ctrl;
    logic        clk = 0;
    logic        rst, flush;
    logic [1:0]  wr_req, wr_gnt, rd_req, rd_gnt;
    logic [31:0] wr_data0, wr_data1, rd_data;
    logic        full, empty;
    logic [4:0]  count;
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    buf_share_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_req(wr_req), .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_data(rd_data),
        .full(full), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (|(rd_req & rd_gnt)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got %0h expected no read", rd_data);
            end else chk("rd_data", rd_data, exp_q.pop_front());
        end
    end

    task automatic step(input logic [1:0] wq, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [1:0] rq, input logic fl,
                        input logic [1:0] ewg, input logic [1:0] erg, input string nm);
        wr_req = wq; wr_data0 = d0; wr_data1 = d1; rd_req = rq; flush = fl;
        if (ewg[0]) exp_q.push_back(d0);
        else if (ewg[1]) exp_q.push_back(d1);
        @(negedge clk);
        chk({nm, "_wr_gnt"}, 32'(wr_gnt), 32'(ewg));
        chk({nm, "_rd_gnt"}, 32'(rd_gnt), 32'(erg));
        @(posedge clk);
        #1;
        wr_req = 0; rd_req = 0; flush = 0;
    endtask

    initial begin
        rst = 1; flush = 0; wr_req = 0; rd_req = 0; wr_data0 = 0; wr_data1 = 0;
        repeat (2) @(posedge clk);
        #1;
        wr_req = 2'b11; rd_req = 2'b11;
        @(negedge clk);
        chk("rst_wr_gnt", 32'(wr_gnt), 0);
        chk("rst_rd_gnt", 32'(rd_gnt), 0);
        @(posedge clk);
        #1;
        rst = 0; wr_req = 0; rd_req = 0;
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_rd_data", rd_data, 0);
        step(2'b00, 0, 0, 2'b01, 0, 2'b00, 2'b00, "rd_empty");

        for (int i = 0; i < 15; i++) step(2'b01, 32'h11 + i, 0, 2'b00, 0, 2'b01, 2'b00, "fill");
        step(2'b01, 32'h20, 0, 2'b00, 0, 2'b01, 2'b00, "fill16");
        chk("full_count", 32'(count), 16);
        chk("full_flag", 32'(full), 1);
        chk("full_empty", 32'(empty), 0);
        step(2'b01, 32'h99, 0, 2'b00, 0, 2'b00, 2'b00, "wr_when_full");
        chk("full_hold", 32'(count), 16);
        step(2'b01, 32'h98, 0, 2'b01, 0, 2'b00, 2'b01, "full_wr_rd");
        chk("after_rd_count", 32'(count), 15);
        step(2'b01, 32'h21, 0, 2'b00, 0, 2'b01, 2'b00, "refill");
        chk("refill_count", 32'(count), 16);
        for (int i = 0; i < 16; i++) step(2'b00, 0, 0, 2'b01, 0, 2'b00, 2'b01, "drain");
        chk("drain_empty", 32'(empty), 1);
        chk("drain_rd_data", rd_data, 0);

        step(2'b00, 0, 0, 2'b00, 1, 2'b00, 2'b00, "flush_idle");
        exp_q.delete();
        for (int k = 0; k < 4; k++)
            step(2'b11, 32'hA0 + k, 32'hB0 + k, 2'b00, 0, (k % 2) ? 2'b10 : 2'b01, 2'b00, "contend");
        for (int k = 0; k < 4; k++) step(2'b00, 0, 0, 2'b01, 0, 2'b00, 2'b01, "contend_rd");

        for (int i = 0; i < 8; i++) step(2'b10, 0, 32'h100 + i, 2'b00, 0, 2'b10, 2'b00, "wrap_fill");
        for (int i = 0; i < 20; i++) begin
            step(2'b01, 32'h200 + i, 0, 2'b10, 0, 2'b01, 2'b10, "simul");
            if (i % 5 == 4) chk("simul_count", 32'(count), 8);
        end
        for (int i = 0; i < 8; i++) step(2'b00, 0, 0, 2'b10, 0, 2'b00, 2'b10, "wrap_drain");
        chk("wrap_empty", 32'(empty), 1);

        for (int i = 0; i < 3; i++) step(2'b01, 32'h300 + i, 0, 2'b00, 0, 2'b01, 2'b00, "arb_fill");
        step(2'b00, 0, 0, 2'b11, 0, 2'b00, 2'b01, "rd_arb0");
        step(2'b00, 0, 0, 2'b11, 0, 2'b00, 2'b10, "rd_arb1");
        step(2'b00, 0, 0, 2'b11, 0, 2'b00, 2'b01, "rd_arb2");
        step(2'b00, 0, 0, 2'b11, 0, 2'b00, 2'b00, "rd_arb_empty");

        for (int i = 0; i < 5; i++) step(2'b01, 32'h400 + i, 0, 2'b00, 0, 2'b01, 2'b00, "pre_flush");
        chk("pre_flush_count", 32'(count), 5);
        step(2'b01, 32'h4FF, 0, 2'b00, 1, 2'b00, 2'b00, "flush_busy");
        exp_q.delete();
        chk("flush_count", 32'(count), 0);
        chk("flush_empty", 32'(empty), 1);
        step(2'b11, 32'h500, 32'h600, 2'b00, 0, 2'b01, 2'b00, "pri_reset");
        step(2'b00, 0, 0, 2'b01, 0, 2'b00, 2'b01, "post_flush_rd");
        chk("sb_left", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
